// File: rtl/fix_point_div_seq.sv
// Sequential signed fixed-point divider: restoring shift-subtract, one quotient bit per clock.
// Optional macro FIX_POINT_DIV_SAT_EN saturates overflowing quotients instead of wrapping.
module fix_point_div_seq #(
    parameter int W_INTEGER_I    = 29,
    parameter int W_FRACTIONAL_I = 3,
    parameter int W_INTEGER_O    = 16,
    parameter int W_FRACTIONAL_O = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [W_INTEGER_I+W_FRACTIONAL_I-1:0]  a,
    input  logic signed [W_INTEGER_I+W_FRACTIONAL_I-1:0]  b,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic signed [W_INTEGER_O+W_FRACTIONAL_O-1:0]  c,
    output logic                                          ovf,
    output logic                                          div_zero
);

    localparam int WI = W_INTEGER_I + W_FRACTIONAL_I;
    localparam int WO = W_INTEGER_O + W_FRACTIONAL_O;
    localparam int WN = WI + W_FRACTIONAL_O;
    localparam int CW = $clog2(WN + 1);

    localparam logic [WN:0]   POS_LIM = {{(WN + 2 - WO){1'b0}}, {(WO - 1){1'b1}}};
    localparam logic [WN:0]   NEG_LIM = {{(WN + 1 - WO){1'b0}}, 1'b1, {(WO - 1){1'b0}}};
    localparam logic [WO-1:0] MAX_C   = {1'b0, {(WO - 1){1'b1}}};
    localparam logic [WO-1:0] MIN_C   = {1'b1, {(WO - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] count_reg;

    // dvd_reg starts as the scaled dividend magnitude; quotient bits shift in at the LSB
    logic [WN:0]   dvd_reg;
    logic [WI:0]   dvs_reg;
    logic [WI:0]   rem_reg;
    logic          sign_reg;
    logic          sign_a_reg;
    logic          zero_reg;

    logic          out_valid_reg;
    logic [WO-1:0] c_reg;
    logic          ovf_reg;
    logic          div_zero_reg;

    logic [WI:0]   a_ext;
    logic [WI:0]   b_ext;
    logic [WI:0]   a_abs;
    logic [WI:0]   b_abs;
    logic          b_zero;

    logic [WI+1:0] rem_shift;
    logic [WI+1:0] dvs_wide;
    logic [WI+1:0] rem_sub;
    logic          q_bit;
    logic [WI:0]   rem_next;

    logic [WN:0]   q_signed;
    logic          ovf_calc;
    logic [WO-1:0] c_calc;
    logic          unused_bits;

    // Operand magnitudes; one extra bit so that |min| is representable
    assign a_ext  = {a[WI-1], a};
    assign b_ext  = {b[WI-1], b};
    assign a_abs  = a[WI-1] ? -a_ext : a_ext;
    assign b_abs  = b[WI-1] ? -b_ext : b_ext;
    assign b_zero = (b == '0);

    assign rem_shift = {rem_reg, dvd_reg[WN]};
    assign dvs_wide  = {1'b0, dvs_reg};
    assign rem_sub   = rem_shift - dvs_wide;
    assign q_bit     = (rem_shift >= dvs_wide);
    assign rem_next  = q_bit ? rem_sub[WI:0] : rem_shift[WI:0];

    // Negative quotients may reach one step further than positive ones
    assign q_signed = sign_reg ? -dvd_reg : dvd_reg;
    assign ovf_calc = sign_reg ? (dvd_reg > NEG_LIM) : (dvd_reg > POS_LIM);

`ifdef FIX_POINT_DIV_SAT_EN
    assign c_calc = ovf_calc ? (sign_reg ? MIN_C : MAX_C) : q_signed[WO-1:0];
`else
    assign c_calc = q_signed[WO-1:0];
`endif

    assign unused_bits = &{1'b0, q_signed[WN:WO], rem_sub[WI+1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_reg == CW'(WN)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid_reg && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = out_valid_reg;
        c         = c_reg;
        ovf       = ovf_reg;
        div_zero  = div_zero_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            sign_reg      <= 1'b0;
            sign_a_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            c_reg         <= '0;
            ovf_reg       <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dvd_reg    <= {a_abs, {W_FRACTIONAL_O{1'b0}}};
                        dvs_reg    <= b_abs;
                        rem_reg    <= '0;
                        sign_reg   <= a[WI-1] ^ b[WI-1];
                        sign_a_reg <= a[WI-1];
                        zero_reg   <= b_zero;
                        count_reg  <= '0;
                    end
                end
                CALC: begin
                    dvd_reg   <= {dvd_reg[WN-1:0], q_bit};
                    rem_reg   <= rem_next;
                    count_reg <= count_reg + CW'(1);
                end
                DONE: begin
                    // First DONE cycle forms the signed result; afterwards hold until taken
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        if (zero_reg) begin
                            c_reg        <= sign_a_reg ? MIN_C : MAX_C;
                            ovf_reg      <= 1'b1;
                            div_zero_reg <= 1'b1;
                        end else begin
                            c_reg        <= c_calc;
                            ovf_reg      <= ovf_calc;
                            div_zero_reg <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_point_div_seq.sv
// Randomized bench for fix_point_div_seq (default parameters) with an arithmetic reference model.
module tb_fix_point_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        ovf;
    logic        div_zero;
    logic [31:0] c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit stall    = 1'b0;

    typedef struct {
        logic [31:0] c;
        logic        ovf;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    bit   front_seen = 1'b0;
    bit   post_rst   = 1'b0;

    always #5 clk = ~clk;

    fix_point_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact signed quotient of (a * 2^16) / b, then range-reduced to 32 bits
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] cv, output logic ov, output logic dz);
        longint sa;
        longint sb;
        longint q;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (sb == 0) begin
            dz = 1'b1;
            ov = 1'b1;
            cv = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            dz = 1'b0;
            q  = (sa * 65536) / sb;
            ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            cv = q[31:0];
`ifdef FIX_POINT_DIV_SAT_EN
            if (ov) cv = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Single compare process: outputs are checked every cycle against the model queue
    always @(negedge clk) begin
        logic [31:0] mc;
        logic        mo;
        logic        md;
        exp_t        e;
        if (rst) begin
            exp_q.delete();
            front_seen = 1'b0;
            post_rst   = 1'b1;
        end else begin
            if (post_rst) begin
                check("reset_c", c, 0);
                check("reset_flags", {out_valid, ovf, div_zero, in_ready}, 4'b0001);
                post_rst = 1'b0;
            end
            check("in_ready", in_ready, exp_q.size() == 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    check("result", {c, ovf, div_zero}, {exp_q[0].c, exp_q[0].ovf, exp_q[0].dz});
                    if (!front_seen) begin
                        check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                        front_seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(a, b, mc, mo, md);
                e.c   = mc;
                e.ovf = mo;
                e.dz  = md;
                e.acc = cyc + 1;
                e.lat = md ? 1 : 50;
                exp_q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        int  n;
        bit  ok;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 500) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic pin(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [33:0] want);
        logic [31:0] mc;
        logic        mo;
        logic        md;
        model(av, bv, mc, mo, md);
        check(name, {mc, mo, md}, want);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] av;
        logic [31:0] bv;

        pin("pin_10_div_4",   32'h50,         32'h20, {32'h0002_8000, 1'b0, 1'b0});
        pin("pin_m7_div_2",   -32'sh38,       32'h10, {32'hFFFC_8000, 1'b0, 1'b0});
        pin("pin_1_div_3",    32'h08,         32'h18, {32'h0000_5555, 1'b0, 1'b0});
        pin("pin_m1_div_3",   -32'sh08,       32'h18, {32'hFFFF_AAAB, 1'b0, 1'b0});
        pin("pin_div0_pos",   32'h28,         32'h0,  {32'h7FFF_FFFF, 1'b1, 1'b1});
        pin("pin_div0_neg",   -32'sh28,       32'h0,  {32'h8000_0000, 1'b1, 1'b1});
`ifdef FIX_POINT_DIV_SAT_EN
        pin("pin_ovf",        32'h4E200,      32'h1,  {32'h7FFF_FFFF, 1'b1, 1'b0});
`else
        pin("pin_ovf",        32'h4E200,      32'h1,  {32'hE200_0000, 1'b1, 1'b0});
`endif
        pin("pin_min_edge",   -32'sh40000,    32'h8,  {32'h8000_0000, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, including range boundaries and min / -1.0
        send(32'h50, 32'h20);        drain();
        send(-32'sh38, 32'h10);      drain();
        send(32'h08, 32'h18);        drain();
        send(-32'sh08, 32'h18);      drain();
        send(32'h28, 32'h0);         drain();
        send(-32'sh28, 32'h0);       drain();
        send(32'h4E200, 32'h1);      drain();
        send(-32'sh40000, 32'h8);    drain();
        send(32'h40000, 32'h8);      drain();
        send(32'h8000_0000, -32'sh8); drain();

        // Back-pressure: result must hold and new operands be ignored
        stall = 1'b1;
        send(32'h50, 32'h20);
        for (int i = 0; i < 60 && !out_valid; i++) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        stall = 1'b0;
        drain();

        // Reset 20 edges into the calculation aborts it
        send(32'h50, 32'h20);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h50, 32'h20);
        drain();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: av = $urandom;
                1: av = {20'h0, 12'($urandom_range(0, 4095))};
                default: av = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) av = -av;
            case ($urandom_range(0, 4))
                0: bv = 32'h0;
                1: bv = 32'($urandom_range(1, 64));
                2: bv = $urandom;
                default: bv = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) bv = -bv;
            send(av, bv);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
